led_pio_ctrl: RTL and testbench
===============================

LED_PIO_CTRL -- requirements
Module: led_pio_ctrl

Interface
REQ-001 Parameter WIDTH, default 10, number of output channels (1..32).
REQ-002 Parameter CNT_W, default 24, blink half-period counter width (1..32).
REQ-003 Parameter RESET_VALUE, default 0, reset value of DATA register (WIDTH bits).
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 address  input  3  Avalon-MM word address.
REQ-007 chipselect  input  1  slave select; writes ignored when low.
REQ-008 write_n  input  1  active-low write strobe.
REQ-009 writedata  input  32  write data.
REQ-010 readdata  output  32  read data, zero-wait-state, zero-extended.
REQ-011 out_port  output  WIDTH  channel drive.

Function
REQ-012 Write occurs on a clk edge where chipselect=1 and write_n=0; takes effect on that edge.
REQ-013 Address map SHALL be: 0 DATA rw; 1 SET wo; 2 CLEAR wo; 3 TOGGLE wo; 4 BLINK rw; 5 PERIOD rw; 6 STATUS ro; 7 reserved.
REQ-014 DATA write: data <= writedata[WIDTH-1:0].
REQ-015 SET write: data <= data | writedata[WIDTH-1:0]; CLEAR: data & ~wd; TOGGLE: data ^ wd.
REQ-016 BLINK write: blink mask <= writedata[WIDTH-1:0].
REQ-017 PERIOD write: period <= writedata[CNT_W-1:0], counter <= 0, phase <= 1 on same edge.
REQ-018 Writes to addresses 6 and 7 SHALL have no effect.
REQ-019 readdata combinational from address regardless of chipselect: 0 data, 4 blink, 5 period, 6 {31'b0, phase}; 1,2,3,7 read 0; unused upper bits 0.
REQ-020 Counter, period!=0, no PERIOD write: counter increments each cycle; when counter==period-1, counter <= 0 and phase toggles.
REQ-021 period==0: counter held 0, phase held 1 (blink frozen in on-phase).
REQ-022 PERIOD write same cycle as terminal count: PERIOD write wins (counter 0, phase 1, no toggle).
REQ-023 Resulting phase period = 2*period cycles; period=1 toggles phase every cycle.
REQ-024 out_port = data & ~(blink & {WIDTH{~phase}}), driven from registered state only; no combinational path from bus inputs to out_port.
REQ-025 Register write visible on out_port and readdata immediately after the write edge (latency 1 edge).
REQ-026 Channels with blink=0 SHALL follow data; channels with blink=1 SHALL show data during phase=1 and 0 during phase=0.

Reset
REQ-027 reset_n low SHALL asynchronously set data=RESET_VALUE, blink=0, period=0, counter=0, phase=1.
REQ-028 Hence out_port=RESET_VALUE and readdata(addr 6)=1 during and after reset.
REQ-029 Reset asserted mid-blink SHALL abort the cycle; after deassertion blinking is off until BLINK and PERIOD rewritten.
REQ-030 Deassertion SHALL be synchronised externally; block takes no action on release other than resuming counting.

Verification
REQ-031 Reset then write DATA=0x3A5 -> out_port=0x3A5 next cycle; read addr 0 = 0x000003A5.
REQ-032 DATA=0x0F0, SET 0x00F, CLEAR 0x030, TOGGLE 0x201 -> out_port 0x0FF, 0x0CF, 0x2CE after each write; reads of addr 1-3 return 0.
REQ-033 DATA=0x3FF, BLINK=0x001, PERIOD=3 -> bit0 high 3 cycles, low 3 cycles, repeating; bits 9:1 steady 1; STATUS.phase matches.
REQ-034 While blinking, write PERIOD=5 on the terminal-count cycle -> no toggle, phase=1, next toggle exactly 5 cycles later.
REQ-035 PERIOD=0 with BLINK=0x3FF, DATA=0x155 -> out_port constant 0x155 for 100 cycles.
REQ-036 Assert reset_n mid-blink during phase=0 -> out_port=RESET_VALUE asynchronously; chipselect=0 writes never alter any register.

Source files
------------

// File: rtl/led_pio_ctrl.sv
// LED / parallel-output controller with an Avalon-MM register slave.
// Each channel is driven from a DATA register and can be gated by a shared
// blink phase generator. Address map (word addresses):
//   0 DATA rw, 1 SET wo, 2 CLEAR wo, 3 TOGGLE wo, 4 BLINK rw, 5 PERIOD rw,
//   6 STATUS ro (bit0 = phase), 7 reserved.
// Bus handshake: a write is accepted on a rising clk edge when
// chipselect=1 and write_n=0; there is no wait state. Reads are purely
// combinational from address and do not depend on chipselect.
module led_pio_ctrl #(
  parameter int unsigned WIDTH       = 10,
  parameter int unsigned CNT_W       = 24,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLEAR  = 3'd2;
  localparam logic [2:0] ADDR_TOGGLE = 3'd3;
  localparam logic [2:0] ADDR_BLINK  = 3'd4;
  localparam logic [2:0] ADDR_PERIOD = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;

  logic [WIDTH-1:0] data_q,   data_d;
  logic [WIDTH-1:0] blink_q,  blink_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             phase_q,  phase_d;

  logic             wr_en;
  logic [WIDTH-1:0] wd_chan;
  logic [CNT_W-1:0] wd_cnt;
  logic [CNT_W-1:0] period_last;

  assign wr_en       = chipselect & ~write_n;
  assign wd_chan     = writedata[WIDTH-1:0];
  assign wd_cnt      = writedata[CNT_W-1:0];
  assign period_last = period_q - {{(CNT_W-1){1'b0}}, 1'b1};

  // Next-state for registers and the blink half-period counter.
  always_comb begin
    data_d   = data_q;
    blink_d  = blink_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;

    if (wr_en) begin
      case (address)
        ADDR_DATA:   data_d   = wd_chan;
        ADDR_SET:    data_d   = data_q | wd_chan;
        ADDR_CLEAR:  data_d   = data_q & ~wd_chan;
        ADDR_TOGGLE: data_d   = data_q ^ wd_chan;
        ADDR_BLINK:  blink_d  = wd_chan;
        ADDR_PERIOD: period_d = wd_cnt;
        default:     ; // STATUS and reserved: writes ignored
      endcase
    end

    // A PERIOD write restarts the phase and beats a simultaneous terminal
    // count; period==0 freezes the generator in its on-phase.
    if (wr_en && (address == ADDR_PERIOD)) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (period_q == '0) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == period_last) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= RESET_VALUE;
      blink_q  <= '0;
      period_q <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b1;
    end else begin
      data_q   <= data_d;
      blink_q  <= blink_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
    end
  end

  // Zero-wait-state read mux, zero-extended to the bus width.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[WIDTH-1:0] = data_q;
      ADDR_BLINK:  readdata[WIDTH-1:0] = blink_q;
      ADDR_PERIOD: readdata[CNT_W-1:0] = period_q;
      ADDR_STATUS: readdata[0]         = phase_q;
      default:     readdata            = '0;
    endcase
  end

  // Blinking channels are blanked during the off-phase; registered state only.
  assign out_port = data_q & ~(blink_q & {WIDTH{~phase_q}});

endmodule

// File: tb/tb_led_pio_ctrl.sv
// Directed bench for led_pio_ctrl: expected values are queued when stimulus
// is driven and popped when the corresponding output is sampled.
module tb_led_pio_ctrl;

  localparam int unsigned WIDTH = 10;
  localparam int unsigned CNT_W = 24;
  localparam logic [WIDTH-1:0] RV = 10'h0C3;

  logic             clk;
  logic             reset_n;
  logic [2:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] out_port;

  logic [31:0] exp_q[$];
  int checks;
  int failures;

  led_pio_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .RESET_VALUE(RV)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard
  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s observed=%h expected=<empty queue>", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  // Drivers (called at a falling edge; write lands on the next rising edge)
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic read_chk(input string tag, input logic [2:0] a, input logic [31:0] e);
    push(e);
    address = a;
    #1;
    check(tag, readdata);
  endtask

  task automatic out_chk(input string tag, input logic [WIDTH-1:0] e);
    push({22'b0, e});
    check(tag, {22'b0, out_port});
  endtask

  initial begin
    logic ph;
    checks     = 0;
    failures   = 0;
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;

    // Reset state
    #12;
    out_chk("rst_out", RV);
    read_chk("rst_status", 3'd6, 32'h1);
    read_chk("rst_data", 3'd0, {22'b0, RV});
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Plain DATA write
    bus_write(3'd0, 32'h0000_03A5);
    out_chk("data_out", 10'h3A5);
    read_chk("data_rd", 3'd0, 32'h0000_03A5);

    // SET / CLEAR / TOGGLE
    bus_write(3'd0, 32'h0F0);
    out_chk("data2_out", 10'h0F0);
    bus_write(3'd1, 32'h00F);
    out_chk("set_out", 10'h0FF);
    read_chk("set_rd", 3'd1, 32'h0);
    bus_write(3'd2, 32'h030);
    out_chk("clear_out", 10'h0CF);
    read_chk("clear_rd", 3'd2, 32'h0);
    bus_write(3'd3, 32'h201);
    out_chk("toggle_out", 10'h2CE);
    read_chk("toggle_rd", 3'd3, 32'h0);
    read_chk("rsvd_rd", 3'd7, 32'h0);

    // Blink bit0 with PERIOD=3: 3 cycles on, 3 off
    bus_write(3'd0, 32'h3FF);
    bus_write(3'd4, 32'h001);
    read_chk("blink_rd", 3'd4, 32'h001);
    bus_write(3'd5, 32'h3);
    for (int k = 0; k < 9; k++) begin
      ph = (((k / 3) % 2) == 0);
      out_chk($sformatf("blink3_out_%0d", k), {9'h1FF, ph});
      read_chk($sformatf("blink3_ph_%0d", k), 3'd6, {31'b0, ph});
      if (k < 8) @(negedge clk);
    end
    read_chk("period_rd", 3'd5, 32'h3);

    // Counter is at terminal count with phase=1: PERIOD write wins
    bus_write(3'd5, 32'h5);
    for (int j = 0; j < 11; j++) begin
      ph = (((j / 5) % 2) == 0);
      out_chk($sformatf("blink5_out_%0d", j), {9'h1FF, ph});
      read_chk($sformatf("blink5_ph_%0d", j), 3'd6, {31'b0, ph});
      @(negedge clk);
    end

    // PERIOD=0 freezes on-phase
    bus_write(3'd5, 32'h0);
    bus_write(3'd4, 32'h3FF);
    bus_write(3'd0, 32'h155);
    for (int c = 0; c < 100; c++) begin
      out_chk($sformatf("frozen_%0d", c), 10'h155);
      @(negedge clk);
    end

    // Reset during off-phase
    bus_write(3'd0, 32'h3FF);
    bus_write(3'd5, 32'h2);
    out_chk("pre_rst_on", 10'h3FF);
    @(negedge clk);
    @(negedge clk);
    out_chk("pre_rst_off", 10'h000);
    #1;
    reset_n = 1'b0;
    #1;
    out_chk("async_rst_out", RV);
    read_chk("async_rst_blink", 3'd4, 32'h0);
    read_chk("async_rst_period", 3'd5, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Writes with chipselect low are ignored
    for (int a = 0; a < 6; a++) begin
      address    = a[2:0];
      writedata  = 32'h0000_03FF;
      write_n    = 1'b0;
      chipselect = 1'b0;
      @(negedge clk);
    end
    write_n = 1'b1;
    read_chk("cs0_data", 3'd0, {22'b0, RV});
    read_chk("cs0_blink", 3'd4, 32'h0);
    read_chk("cs0_period", 3'd5, 32'h0);

    // STATUS / reserved writes have no effect
    bus_write(3'd6, 32'h0);
    bus_write(3'd7, 32'h3FF);
    read_chk("wr6_status", 3'd6, 32'h1);
    read_chk("wr7_data", 3'd0, {22'b0, RV});
    for (int c = 0; c < 6; c++) begin
      out_chk($sformatf("post_rst_%0d", c), RV);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
